// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - multi-cycle load/store unit with req/gnt/rvalid bus handshake
module lsu_bus_ctrl #(
    parameter int                         NUM_REGIONS  = 2,
    parameter logic [4*NUM_REGIONS-1:0]   REGION_BASES = {4'h8, 4'h0},
    parameter int                         TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_valid,
    input  logic [4:0]             mem_op,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_data_wr,
    output logic [31:0]            cpu_data_rd,
    output logic                   cpu_done,
    output logic                   stall,
    output logic                   fault,
    output logic [1:0]             fault_cause,
    output logic                   dbus_req,
    input  logic                   dbus_gnt,
    input  logic                   dbus_rvalid,
    input  logic [31:0]            dbus_data_rd,
    output logic [31:0]            dbus_addr,
    output logic [31:0]            dbus_data_wr,
    output logic [3:0]             dbus_mask,
    output logic                   dbus_wr,
    output logic [NUM_REGIONS-1:0] dbus_sel
);

    localparam logic [4:0] OP_LB  = 5'b00001;
    localparam logic [4:0] OP_LH  = 5'b00010;
    localparam logic [4:0] OP_LW  = 5'b00011;
    localparam logic [4:0] OP_LBU = 5'b00100;
    localparam logic [4:0] OP_LHU = 5'b00101;
    localparam logic [4:0] OP_SB  = 5'b10110;
    localparam logic [4:0] OP_SH  = 5'b10111;
    localparam logic [4:0] OP_SW  = 5'b11000;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'b11;

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           wait_cnt;
    logic [4:0]              op_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [NUM_REGIONS-1:0]  hit_q;

    logic                    op_known, op_half, op_word, misaligned, accept;
    logic [NUM_REGIONS-1:0]  hit_sel;
    logic                    busy, wait_expired;
    logic                    d_fault;
    logic [1:0]              d_cause;
    logic [31:0]             d_data;

    function automatic logic [31:0] load_ext(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0, h};
            OP_LW:   load_ext = d;
            default: load_ext = 32'h0;
        endcase
    endfunction

    always_comb begin
        op_known = 1'b1;
        op_half  = 1'b0;
        op_word  = 1'b0;
        case (mem_op)
            OP_LB, OP_LBU, OP_SB: ;
            OP_LH, OP_LHU, OP_SH: op_half = 1'b1;
            OP_LW, OP_SW:         op_word = 1'b1;
            default:              op_known = 1'b0;
        endcase
    end

    assign misaligned = (op_half & cpu_addr[0]) | (op_word & (|cpu_addr[1:0]));
    // Gated by rst_n so stall stays low while reset is held.
    assign accept = rst_n && (state == IDLE) && cpu_valid && op_known;

    // Lowest-index region wins when several bases alias the same nibble.
    always_comb begin
        logic found;
        found   = 1'b0;
        hit_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!found && (REGION_BASES[4*i +: 4] == cpu_addr[31:28])) begin
                hit_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign busy         = (state == REQ) || (state == RESP);
    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        d_fault    = 1'b0;
        d_cause    = 2'b00;
        d_data     = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = DONE;
                        d_fault    = 1'b1;
                        d_cause    = CAUSE_MISALIGN;
                    end else if (hit_sel == '0) begin
                        state_next = DONE;
                        d_fault    = 1'b1;
                        d_cause    = CAUSE_UNMAPPED;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (dbus_gnt) begin
                    if (op_q[4]) begin
                        state_next = DONE;
                    end else if (dbus_rvalid) begin
                        state_next = DONE;
                        d_data     = load_ext(op_q, addr_q[1:0], dbus_data_rd);
                    end else begin
                        state_next = RESP;
                    end
                end else if (wait_expired) begin
                    state_next = DONE;
                    d_fault    = 1'b1;
                    d_cause    = CAUSE_TIMEOUT;
                end
            end
            RESP: begin
                if (dbus_rvalid) begin
                    state_next = DONE;
                    d_data     = load_ext(op_q, addr_q[1:0], dbus_data_rd);
                end else if (wait_expired) begin
                    state_next = DONE;
                    d_fault    = 1'b1;
                    d_cause    = CAUSE_TIMEOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall        = busy || accept;
        dbus_req     = (state == REQ);
        dbus_sel     = busy ? hit_q : '0;
        dbus_wr      = busy & op_q[4];
        dbus_addr    = busy ? addr_q : 32'h0;
        dbus_mask    = 4'h0;
        dbus_data_wr = 32'h0;
        if (busy) begin
            case (op_q)
                OP_LB, OP_LBU: dbus_mask = 4'b0001 << addr_q[1:0];
                OP_LH, OP_LHU: dbus_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                OP_LW:         dbus_mask = 4'b1111;
                OP_SB: begin
                    dbus_mask    = 4'b0001 << addr_q[1:0];
                    dbus_data_wr = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                end
                OP_SH: begin
                    dbus_mask    = addr_q[1] ? 4'b1100 : 4'b0011;
                    dbus_data_wr = addr_q[1] ? {wdata_q[15:0], 16'h0} : {16'h0, wdata_q[15:0]};
                end
                OP_SW: begin
                    dbus_mask    = 4'b1111;
                    dbus_data_wr = wdata_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 5'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            hit_q   <= '0;
        end else if (accept) begin
            op_q    <= mem_op;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_data_wr;
            hit_q   <= hit_sel;
        end
    end

    // Counter restarts on every state change, so REQ and RESP each get a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next != state || !busy) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_done    <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            cpu_data_rd <= 32'h0;
        end else begin
            cpu_done    <= (state_next == DONE);
            fault       <= d_fault;
            fault_cause <= d_cause;
            cpu_data_rd <= d_data;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - table-driven bench for lsu_bus_ctrl
module tb_lsu_bus_ctrl;

    localparam logic [4:0] LB  = 5'b00001;
    localparam logic [4:0] LH  = 5'b00010;
    localparam logic [4:0] LW  = 5'b00011;
    localparam logic [4:0] LBU = 5'b00100;
    localparam logic [4:0] LHU = 5'b00101;
    localparam logic [4:0] SB  = 5'b10110;
    localparam logic [4:0] SH  = 5'b10111;
    localparam logic [4:0] SW  = 5'b11000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [4:0]  mem_op = 5'h0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_data_wr = 32'h0;
    logic [31:0] cpu_data_rd;
    logic        cpu_done, stall, fault;
    logic [1:0]  fault_cause;
    logic        dbus_req;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_data_rd = 32'h0;
    logic [31:0] dbus_addr, dbus_data_wr;
    logic [3:0]  dbus_mask;
    logic        dbus_wr;
    logic [1:0]  dbus_sel;

    int checks = 0;
    int failures = 0;

    lsu_bus_ctrl #(.NUM_REGIONS(2), .REGION_BASES({4'h8, 4'h0}), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .mem_op(mem_op),
        .cpu_addr(cpu_addr), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
        .cpu_done(cpu_done), .stall(stall), .fault(fault), .fault_cause(fault_cause),
        .dbus_req(dbus_req), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_data_rd(dbus_data_rd), .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr),
        .dbus_mask(dbus_mask), .dbus_wr(dbus_wr), .dbus_sel(dbus_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_cyc;
        int          rv_cyc;
        int          exp_done;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [31:0] exp_rd;
        logic        exp_bus;
        logic        exp_wr;
        logic [3:0]  exp_mask;
        logic [1:0]  exp_sel;
        logic [31:0] exp_dwr;
        int          exp_req;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int req_cnt = 0;
        bit seen = 0;
        @(negedge clk);
        cpu_valid = 1'b1; mem_op = v.op; cpu_addr = v.addr; cpu_data_wr = v.wdata;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_data_rd = v.rdata;
        #1 chk($sformatf("v%0d_stall_accept", idx), stall, 1);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            cpu_valid = 1'b0; mem_op = 5'h0;
            dbus_gnt = (c == v.gnt_cyc); dbus_rvalid = (c == v.rv_cyc);
            #1;
            if (dbus_req) req_cnt++;
            if (c == 1) begin
                chk($sformatf("v%0d_req", idx), dbus_req, v.exp_bus);
                chk($sformatf("v%0d_sel", idx), dbus_sel, v.exp_bus ? v.exp_sel : 2'b00);
                if (v.exp_bus) begin
                    chk($sformatf("v%0d_addr", idx), dbus_addr, v.addr);
                    chk($sformatf("v%0d_mask", idx), dbus_mask, v.exp_mask);
                    chk($sformatf("v%0d_wr", idx), dbus_wr, v.exp_wr);
                    chk($sformatf("v%0d_dwr", idx), dbus_data_wr, v.exp_dwr);
                end
            end
            if (cpu_done) begin
                seen = 1;
                chk($sformatf("v%0d_done_cycle", idx), c, v.exp_done);
                chk($sformatf("v%0d_fault", idx), fault, v.exp_fault);
                chk($sformatf("v%0d_cause", idx), fault_cause, v.exp_cause);
                chk($sformatf("v%0d_rd", idx), cpu_data_rd, v.exp_rd);
                chk($sformatf("v%0d_stall_done", idx), stall, 0);
                chk($sformatf("v%0d_sel_done", idx), dbus_sel, 0);
            end else begin
                chk($sformatf("v%0d_stall_c%0d", idx, c), stall, c < v.exp_done);
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL v%0d_done_timeout actual=none required=cycle%0d", idx, v.exp_done);
        end
        chk($sformatf("v%0d_req_cycles", idx), req_cnt, v.exp_req);
        @(negedge clk);
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        #1 chk($sformatf("v%0d_done_pulse", idx), cpu_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [8:0] done_bits;
        vec_t sh_vec;

        //           op   addr          wdata         rdata         g  rv dn  f cause  rd            bus wr mask     sel    dwr           req
        vq.push_back('{SW,  32'h00000104, 32'hDEADBEEF, 32'h0,        1, 0, 2,  0, 2'b00, 32'h0,        1, 1, 4'b1111, 2'b01, 32'hDEADBEEF, 1});
        vq.push_back('{LB,  32'h00000003, 32'h0,        32'h80FF1234, 1, 4, 5,  0, 2'b00, 32'hFFFFFF80, 1, 0, 4'b1000, 2'b01, 32'h0,        1});
        vq.push_back('{LBU, 32'h00000003, 32'h0,        32'h80FF1234, 1, 4, 5,  0, 2'b00, 32'h00000080, 1, 0, 4'b1000, 2'b01, 32'h0,        1});
        vq.push_back('{LH,  32'h00000001, 32'h0,        32'h0,        0, 0, 1,  1, 2'b01, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0,        0});
        vq.push_back('{LW,  32'h00000002, 32'h0,        32'h0,        0, 0, 1,  1, 2'b01, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0,        0});
        vq.push_back('{SB,  32'h40000000, 32'h00000055, 32'h0,        0, 0, 1,  1, 2'b11, 32'h0,        0, 0, 4'b0000, 2'b00, 32'h0,        0});
        vq.push_back('{SB,  32'h80000001, 32'h00000055, 32'h0,        1, 0, 2,  0, 2'b00, 32'h0,        1, 1, 4'b0010, 2'b10, 32'h00005500, 1});
        vq.push_back('{LW,  32'h00000000, 32'h0,        32'h0,        0, 0, 17, 1, 2'b10, 32'h0,        1, 0, 4'b1111, 2'b01, 32'h0,        16});
        vq.push_back('{LH,  32'h80000002, 32'h0,        32'h80010000, 1, 1, 2,  0, 2'b00, 32'hFFFF8001, 1, 0, 4'b1100, 2'b10, 32'h0,        1});
        vq.push_back('{LHU, 32'h00000006, 32'h0,        32'h1234ABCD, 3, 3, 4,  0, 2'b00, 32'h00001234, 1, 0, 4'b1100, 2'b01, 32'h0,        3});
        vq.push_back('{SH,  32'h00000002, 32'hAAAABEEF, 32'h0,        1, 0, 2,  0, 2'b00, 32'h0,        1, 1, 4'b1100, 2'b01, 32'hBEEF0000, 1});
        vq.push_back('{LW,  32'h00000010, 32'h0,        32'hCAFEF00D, 1, 2, 3,  0, 2'b00, 32'hCAFEF00D, 1, 0, 4'b1111, 2'b01, 32'h0,        1});
        vq.push_back('{LB,  32'h00000001, 32'h0,        32'h00007F00, 1, 2, 3,  0, 2'b00, 32'h0000007F, 1, 0, 4'b0010, 2'b01, 32'h0,        1});
        vq.push_back('{LW,  32'h00000020, 32'h0,        32'h0,        1, 0, 18, 1, 2'b10, 32'h0,        1, 0, 4'b1111, 2'b01, 32'h0,        1});
        vq.push_back('{LW,  32'h00000004, 32'h0,        32'h12345678, 2, 1, 19, 1, 2'b10, 32'h0,        1, 0, 4'b1111, 2'b01, 32'h0,        2});
        vq.push_back('{SB,  32'h00000083, 32'h000000A5, 32'h0,        1, 0, 2,  0, 2'b00, 32'h0,        1, 1, 4'b1000, 2'b01, 32'hA5000000, 1});
        sh_vec = '{SH, 32'h00000002, 32'h00001234, 32'h0, 1, 0, 2, 0, 2'b00, 32'h0, 1, 1, 4'b1100, 2'b01, 32'h12340000, 1};

        // Reset state, with a valid op presented during reset.
        cpu_valid = 1'b1; mem_op = LW;
        @(negedge clk); #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", cpu_done, 0);
        chk("rst_req", dbus_req, 0);
        chk("rst_sel", dbus_sel, 0);
        chk("rst_fault", {fault, fault_cause}, 0);
        chk("rst_rd", cpu_data_rd, 0);
        chk("rst_bus", {dbus_wr, dbus_mask, dbus_addr}, 0);
        cpu_valid = 1'b0; mem_op = 5'h0;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

        // Unknown op encoding is not accepted.
        @(negedge clk);
        cpu_valid = 1'b1; mem_op = 5'b01010; cpu_addr = 32'h0;
        #1 chk("badop_stall", stall, 0);
        @(negedge clk);
        cpu_valid = 1'b0; mem_op = 5'h0;
        #1 chk("badop_req", {dbus_req, cpu_done}, 0);

        // Back-to-back stores with cpu_valid held: accepts at 0,3,6.
        @(negedge clk);
        cpu_valid = 1'b1; mem_op = SW; cpu_addr = 32'h100; cpu_data_wr = 32'h1; dbus_gnt = 1'b1;
        done_bits = '0;
        for (int c = 0; c <= 8; c++) begin
            #1;
            done_bits[c] = cpu_done;
            if (c == 2) chk("b2b_stall_in_done", stall, 0);
            @(negedge clk);
        end
        chk("b2b_done_pattern", done_bits, 9'b100100100);
        cpu_valid = 1'b0; mem_op = 5'h0; dbus_gnt = 1'b0;
        @(negedge clk);

        // Reset asserted while a load waits in RESP.
        @(negedge clk);
        cpu_valid = 1'b1; mem_op = LW; cpu_addr = 32'h0;
        @(negedge clk);
        cpu_valid = 1'b0; mem_op = 5'h0; dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1;
        chk("midrst_in_resp_sel", dbus_sel, 2'b01);
        chk("midrst_in_resp_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", dbus_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_done", cpu_done, 0);
        chk("midrst_sel", dbus_sel, 0);
        @(negedge clk); rst_n = 1'b1;
        run_vec(100, sh_vec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
